cla_chunked_addsub: RTL and testbench
=====================================

Name: cla_chunked_addsub

Overview:
- Multi-cycle, parametrised add/subtract unit for the calculator datapath. Successor to the combinational carry-lookahead adder.
- Processes an N-bit operation K bits per cycle:
  - a K-bit carry-lookahead slice computes each chunk;
  - a registered carry passes between chunks.
- Adds subtract mode, carry-out, signed overflow and zero flags.
- Uses a valid/ready handshake so it sits between operand-entry logic and the result/display stage.

Parameters:
- N, 16, operand/result width in bits. Must be a multiple of K, N >= 2.
- K, 4, chunk width processed per cycle by the lookahead slice. 1 <= K <= N.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand set present
- in_ready  out  1  block can accept operands (high only in IDLE)
- a  in  N  operand A
- b  in  N  operand B
- sub  in  1  1 = A - B, 0 = A + B
- cin  in  1  carry-in for add; ignored when sub=1
- out_valid  out  1  result held and valid
- out_ready  in  1  consumer accepts result
- sum  out  N  result
- cout  out  1  carry out of bit N-1 (for sub: 1 = no borrow)
- ovf  out  1  signed two's-complement overflow
- zero  out  1  sum == 0

Behaviour:
- Clock and reset:
  - One clock: clk.
  - rst_n is asynchronous and active-low. Assertion immediately forces state IDLE and clears all registers: sum=0, cout=0, ovf=0, zero=0, out_valid=0, chunk index=0, carry=0.
  - in_ready=1 while in reset.
  - Reset mid-operation aborts it with no output.
- States: IDLE, RUN, DONE. Two-bit state register; unused encodings go to IDLE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On clk with in_valid=1, capture:
    - a;
    - b_eff = sub ? ~b : b;
    - carry = sub ? 1 : cin.
  - Then set chunk index to 0 and move to RUN.
- RUN, one chunk per cycle, chunk i = bits [i*K+K-1 : i*K]:
  - Compute sum chunk, chunk carry-out and carry into the chunk MSB with full K-bit lookahead (generate/propagate) from the registered carry. No ripple.
  - Write the sum chunk into the sum register and set carry <= chunk carry-out.
  - On the last chunk (i = N/K - 1):
    - cout <= chunk carry-out;
    - ovf <= carry into bit N-1 XOR carry out of bit N-1;
    - zero <= (final sum == 0);
    - go to DONE.
  - in_ready=0.
- DONE:
  - out_valid=1.
  - sum, cout, ovf and zero are stable for as long as out_ready=0.
  - On clk with out_ready=1, go to IDLE (out_valid falls).
  - in_valid is ignored.
- Timing:
  - Latency: out_valid rises exactly N/K clocks after the accepting edge.
  - Minimum initiation interval is N/K+2 cycles.
- Outputs:
  - sum bits of chunks not yet computed hold their previous values until overwritten. sum is only meaningful when out_valid=1.
  - Flags update only on the last RUN cycle.
- Degenerate K=N: a single RUN cycle; latency is 1.
- Simultaneous events:
  - in_valid is ignored outside IDLE.
  - out_ready is ignored outside DONE.
  - Operand changes after acceptance have no effect.
- Width rules:
  - All arithmetic is modulo 2^N.
  - The chunk index counter is clog2(N/K) bits wide (minimum 1) and wraps only via the IDLE reload.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined:
  - When the final ovf=1, sum is replaced with signed saturation: 0x7FF..F if operand A is non-negative, 0x800..0 if A is negative.
  - ovf is still reported as 1.
  - zero is computed on the saturated value.
  - The substitution happens on the last RUN cycle, so latency is unchanged.
- Not defined: sum is the wrapped modulo-2^N result.

Test Plan (N=16, K=4):
- Latency and basic add: a=0x1234, b=0x1111, sub=0, cin=0, in_valid=1 one cycle -> out_valid exactly 4 clocks later, sum=0x2345, cout=0, ovf=0, zero=0.
- Add with carry and zero:
  - a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0, zero=1.
  - Same with cin=1 -> sum=0x0001, zero=0.
- Signed add overflow: a=0x7FFF, b=0x0001, add -> ovf=1, sum=0x8000 without the macro, 0x7FFF with ADDSUB_SAT_EN.
- Subtract:
  - a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0.
  - a=0x8000, b=0x0001, sub=1 -> ovf=1, sum=0x7FFF without the macro, 0x8000 with it.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid, toggling in_valid and operands -> in_ready=0 throughout, sum and flags unchanged; raising out_ready for one cycle -> next cycle out_valid=0, in_ready=1.
- Reset mid-operation: drop rst_n asynchronously after 2 RUN cycles -> out_valid=0 and sum=0 immediately; after release in_ready=1, no spurious out_valid, and a new operation completes correctly.

Source files
------------

// File: rtl/cla_chunked_addsub.sv
// Multi-cycle add/subtract: one K-bit lookahead chunk per clock, registered carry between chunks.
// Optional signed saturation on overflow when ADDSUB_SAT_EN is defined.
module cla_chunked_addsub #(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int NC = N / K;
  localparam int IW = (NC > 1) ? $clog2(NC) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [N-1:0]   r_sum;
  logic           r_carry;
  logic           r_cout;
  logic           r_ovf;
  logic           r_zero;
  logic [IW-1:0]  r_idx;

  logic [K-1:0]   w_ak;
  logic [K-1:0]   w_bk;
  logic [K-1:0]   w_g;
  logic [K-1:0]   w_p;
  logic [K-1:0]   w_sk;
  logic [K:0]     w_c;
  logic           w_last;
  logic           w_ovf;
  logic [N-1:0]   w_fin;
  logic [N-1:0]   w_res;

  assign w_last = (r_idx == IW'(NC - 1));

  always_comb begin
    w_ak = '0;
    w_bk = '0;
    for (int c = 0; c < NC; c++) begin
      if (r_idx == IW'(c)) begin
        w_ak = r_a[c*K +: K];
        w_bk = r_b[c*K +: K];
      end
    end
  end

  // Each carry is a flat sum of generate/propagate products.
  always_comb begin : cla
    logic t;
    t   = 1'b0;
    w_g = w_ak & w_bk;
    w_p = w_ak ^ w_bk;
    w_c = '0;
    w_c[0] = r_carry;
    for (int j = 0; j < K; j++) begin
      t = r_carry;
      for (int m = 0; m <= j; m++) t = t & w_p[m];
      w_c[j+1] = t;
      for (int m = 0; m <= j; m++) begin
        t = w_g[m];
        for (int q = m + 1; q <= j; q++) t = t & w_p[q];
        w_c[j+1] = w_c[j+1] | t;
      end
    end
    w_sk = w_p ^ w_c[K-1:0];
  end

  always_comb begin
    w_fin = r_sum;
    w_fin[N-1 -: K] = w_sk;
    w_ovf = w_c[K] ^ w_c[K-1];
`ifdef ADDSUB_SAT_EN
    if (w_ovf)
      w_res = r_a[N-1] ? {1'b1, {(N-1){1'b0}}}
                       : {1'b0, {(N-1){1'b1}}};
    else
      w_res = w_fin;
`else
    w_res = w_fin;
`endif
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub | cin;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_carry <= w_c[K];
          if (w_last) begin
            r_sum  <= w_res;
            r_cout <= w_c[K];
            r_ovf  <= w_ovf;
            r_zero <= (w_res == '0);
          end else begin
            r_idx <= r_idx + 1'b1;
            for (int c = 0; c < NC; c++)
              if (r_idx == IW'(c)) r_sum[c*K +: K] <= w_sk;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_cla_chunked_addsub.sv
// Bench for cla_chunked_addsub (N=16, K=4): directed vectors plus
// randomized operations checked against an arithmetic reference model.
module tb_cla_chunked_addsub;

  localparam int N   = 16;
  localparam int K   = 4;
  localparam int LAT = N / K;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  int total = 0;
  int bad   = 0;

  cla_chunked_addsub #(.N(N), .K(K)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {sum, cout, ovf, zero} from signed/unsigned integer arithmetic
  function automatic logic [N+2:0] model(
    input logic [N-1:0] x, input logic [N-1:0] y,
    input logic s, input logic ci);
    int sx, sy, sv;
    logic [N-1:0] r;
    logic co, ov;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      r  = x - y;
      co = (x >= y);
      sv = sx - sy;
    end else begin
      r  = x + y + N'(ci);
      co = ((int'(x) + int'(y) + int'(ci)) >= (1 << N));
      sv = sx + sy + int'(ci);
    end
    ov = (sv > (1 << (N-1)) - 1) || (sv < -(1 << (N-1)));
`ifdef ADDSUB_SAT_EN
    if (ov) r = x[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
    return {r, co, ov, (r == '0)};
  endfunction

  task automatic start_op(input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic s, input logic ci);
    a = x; b = y; sub = s; cin = ci;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit tmo);
    lat = 0;
    tmo = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        tmo = 1'b0;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    #3;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_hs: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    total++;
    if ({sum, cout, ovf, zero} !== '0) begin
      bad++;
      $display("FAIL reset_regs: got %h %b%b%b want 0", sum, cout, ovf, zero);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [N-1:0] va[6], vb[6], vs[6];
    logic         vsub[6], vci[6];
    logic [2:0]   vf[6];
    int lat;
    bit tmo;
    va = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    vb = '{16'h1111, 16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
    vsub = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vci  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef ADDSUB_SAT_EN
    vs = '{16'h2345, 16'h0000, 16'h0001, 16'h7FFF, 16'hFFFE, 16'h8000};
`else
    vs = '{16'h2345, 16'h0000, 16'h0001, 16'h8000, 16'hFFFE, 16'h7FFF};
`endif
    vf = '{3'b000, 3'b101, 3'b100, 3'b010, 3'b000, 3'b110};
    for (int i = 0; i < 6; i++) begin
      start_op(va[i], vb[i], vsub[i], vci[i]);
      wait_done(lat, tmo);
      total++;
      if (tmo || lat != LAT) begin
        bad++;
        $display("FAIL dir%0d_latency: got %0d tmo=%b want %0d", i, lat, tmo, LAT);
      end
      total++;
      if (sum !== vs[i]) begin
        bad++;
        $display("FAIL dir%0d_sum: got %h want %h", i, sum, vs[i]);
      end
      total++;
      if ({cout, ovf, zero} !== vf[i]) begin
        bad++;
        $display("FAIL dir%0d_flags: got %b want %b", i, {cout, ovf, zero}, vf[i]);
      end
      release_out();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL dir%0d_release: got v=%b r=%b want v=0 r=1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] x, y;
    logic s, ci;
    logic [N+2:0] exp;
    int lat;
    bit tmo;
    for (int i = 0; i < 30; i++) begin
      x = N'($urandom); y = N'($urandom);
      s = 1'($urandom); ci = 1'($urandom);
      if (i % 5 == 0) y = s ? x : (~x + N'(!ci));
      exp = model(x, y, s, ci);
      start_op(x, y, s, ci);
      wait_done(lat, tmo);
      total++;
      if (tmo || lat != LAT || {sum, cout, ovf, zero} !== exp) begin
        bad++;
        $display("FAIL rand%0d: a=%h b=%h s=%b c=%b got %h lat=%0d want %h",
                 i, x, y, s, ci, {sum, cout, ovf, zero}, lat, exp);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [N+2:0] exp;
    int lat;
    bit tmo;
    bit err;
    exp = model(16'hABCD, 16'h4321, 1'b1, 1'b0);
    start_op(16'hABCD, 16'h4321, 1'b1, 1'b0);
    wait_done(lat, tmo);
    total++;
    if (tmo) begin
      bad++;
      $display("FAIL bp_timeout: got no out_valid want out_valid");
    end
    err = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'($urandom);
      a = N'($urandom); b = N'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          {sum, cout, ovf, zero} !== exp) err = 1'b1;
    end
    total++;
    if (err) begin
      bad++;
      $display("FAIL bp_hold: got %h r=%b v=%b want %h r=0 v=1",
               {sum, cout, ovf, zero}, in_ready, out_valid, exp);
    end
    in_valid = 1'b0;
    release_out();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [N+2:0] exp;
    int lat;
    bit tmo;
    bit err;
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || sum !== '0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_async: got v=%b sum=%h r=%b want v=0 sum=0 r=1",
               out_valid, sum, in_ready);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    err = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) err = 1'b1;
    end
    total++;
    if (err) begin
      bad++;
      $display("FAIL rstmid_spurious: got out_valid/in_ready change want idle");
    end
    exp = model(16'h0F0F, 16'h00F1, 1'b0, 1'b1);
    start_op(16'h0F0F, 16'h00F1, 1'b0, 1'b1);
    wait_done(lat, tmo);
    total++;
    if (tmo || lat != LAT || {sum, cout, ovf, zero} !== exp) begin
      bad++;
      $display("FAIL rstmid_newop: got %h lat=%0d want %h", {sum, cout, ovf, zero}, lat, exp);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [N+2:0] q[$];
    logic [N+2:0] exp;
    int last_acc;
    int nacc;
    bit err_res;
    bit err_ii;
    last_acc = -1;
    nacc = 0;
    err_res = 1'b0;
    err_ii = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      a = N'($urandom); b = N'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      if (in_ready) begin
        q.push_back(model(a, b, sub, cin));
        if (last_acc >= 0 && cyc - last_acc != LAT + 2) err_ii = 1'b1;
        last_acc = cyc;
        nacc++;
      end
      @(posedge clk); #1;
      if (out_valid) begin
        if (q.size() == 0) err_res = 1'b1;
        else begin
          exp = q.pop_front();
          if ({sum, cout, ovf, zero} !== exp) err_res = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        exp = q.pop_front();
        if ({sum, cout, ovf, zero} !== exp) err_res = 1'b1;
      end
    end
    out_ready = 1'b0;
    total++;
    if (err_res || q.size() != 0) begin
      bad++;
      $display("FAIL b2b_results: got mismatch or %0d pending want all match", q.size());
    end
    total++;
    if (err_ii || nacc < 5) begin
      bad++;
      $display("FAIL b2b_interval: got accepts=%0d ii_err=%b want >=5 at ii=%0d",
               nacc, err_ii, LAT + 2);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
